// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a byte stream into big-endian
// words, writes them to consecutive addresses, holds the core in reset.
module imem_loader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_write_enable,
  output logic [ADDR_W-1:0] im_write_address,
  output logic [DATA_W-1:0] im_write_data,
  output logic              core_reset_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [BW-1:0]     byte_cnt;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] shifted;
  logic              last_byte;
  logic              take;

  // Earlier bytes move toward the MSB, so byte 0 ends up on top.
  assign shifted   = DATA_W'({word, in_data});
  assign last_byte = (byte_cnt == BW'(NB - 1));
  assign take      = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      addr             <= '0;
      remaining        <= '0;
      byte_cnt         <= '0;
      word             <= '0;
      in_ready         <= 1'b0;
      im_write_enable  <= 1'b0;
      im_write_address <= '0;
      im_write_data    <= '0;
      core_reset_n     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      checksum         <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= word_count;
            checksum  <= '0;
            byte_cnt  <= '0;
            word      <= '0;
            if (word_count == '0) begin
              state        <= DONE;
              done         <= 1'b1;
              core_reset_n <= 1'b1;
            end else begin
              state        <= LOAD;
              done         <= 1'b0;
              core_reset_n <= 1'b0;
              in_ready     <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (take) begin
            word     <= shifted;
            byte_cnt <= byte_cnt + BW'(1);
            if (last_byte) begin
              state            <= WRITE;
              byte_cnt         <= '0;
              in_ready         <= 1'b0;
              im_write_enable  <= 1'b1;
              im_write_address <= addr;
              im_write_data    <= shifted;
            end
          end
        end
        WRITE: begin
          im_write_enable <= 1'b0;
          checksum        <= checksum ^ im_write_data;
          addr            <= addr + ADDR_W'(1);
          remaining       <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            core_reset_n <= 1'b1;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of loads plus hand-written
// sequences for reset, zero count, ignored start and reload.
module tb_imem_loader;

  logic        clock = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [31:0] base_addr = 0;
  logic [15:0] word_count = 0;
  logic        in_valid = 0;
  logic [7:0]  in_data = 0;

  logic        in_ready, im_write_enable, core_reset_n, busy, done;
  logic [31:0] im_write_address, im_write_data, checksum;

  logic        s_in_ready, s_we, s_core_reset_n, s_busy, s_done;
  logic [3:0]  s_addr;
  logic [31:0] s_data, s_checksum;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int acc    = 0;
  int last_cyc = 0;
  int lat_err  = 0;
  int rdy_err  = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  sa_q[$];

  imem_loader dut (
    .clock(clock), .reset(reset), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .im_write_enable(im_write_enable),
    .im_write_address(im_write_address),
    .im_write_data(im_write_data),
    .core_reset_n(core_reset_n),
    .busy(busy), .done(done), .checksum(checksum)
  );

  imem_loader #(.ADDR_W(4)) dut_s (
    .clock(clock), .reset(reset), .start(start),
    .base_addr(base_addr[3:0]), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready),
    .im_write_enable(s_we),
    .im_write_address(s_addr),
    .im_write_data(s_data),
    .core_reset_n(s_core_reset_n),
    .busy(s_busy), .done(s_done), .checksum(s_checksum)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // A byte seen valid&&ready here is taken on the next rising edge.
  always @(negedge clock) begin
    if (in_valid && in_ready) begin
      acc++;
      if (acc % 4 == 0) last_cyc = cyc;
    end
    if (im_write_enable) begin
      wa_q.push_back(im_write_address);
      wd_q.push_back(im_write_data);
      if (cyc - last_cyc != 1) lat_err++;
      if (in_ready) rdy_err++;
    end
    if (s_we) sa_q.push_back(s_addr);
  end

  typedef struct {
    logic [31:0] base;
    logic [15:0] cnt;
    logic [63:0] bytes;
    bit          gaps;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  s0, s1;
    logic [31:0] cs;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    sa_q.delete();
    acc = 0;
    lat_err = 0;
    rdy_err = 0;
  endtask

  task automatic start_load(input logic [31:0] b, input logic [15:0] n);
    start = 1;
    base_addr = b;
    word_count = n;
    @(posedge clock); #1;
    start = 0;
  endtask

  task automatic send(input logic [63:0] s, input int n,
                      input bit gaps, input bit noise);
    int i = 0;
    int c = 0;
    bit v;
    bit r;
    while (i < n && c < 400) begin
      v = !(gaps && c[0]);
      in_valid = v;
      in_data = s[63-8*i -: 8];
      if (noise) begin
        start = c[1];
        base_addr = 32'h55;
        word_count = 16'd7;
      end
      r = in_ready;
      @(posedge clock); #1;
      if (v && r) i++;
      c++;
    end
    in_valid = 0;
    start = 0;
    chk("send_timeout", i, n);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    chk("done_timeout", k < 200, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_we"}, im_write_enable, 0);
    chk({tag, "_waddr"}, im_write_address, 0);
    chk({tag, "_wdata"}, im_write_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_core_rst_n"}, core_reset_n, 0);
  endtask

  initial begin
    vecs[0] = '{32'h0, 16'd2, 64'h20010005_20020007, 1'b0,
                32'h0, 32'h20010005, 32'h1, 32'h20020007,
                4'h0, 4'h1, 32'h00030002};
    vecs[1] = '{32'h0, 16'd2, 64'h20010005_20020007, 1'b1,
                32'h0, 32'h20010005, 32'h1, 32'h20020007,
                4'h0, 4'h1, 32'h00030002};
    vecs[2] = '{32'hF, 16'd2, 64'hdeadbeef_01234567, 1'b0,
                32'hF, 32'hdeadbeef, 32'h10, 32'h01234567,
                4'hF, 4'h0, 32'hdf8efb88};
    vecs[3] = '{32'h100, 16'd1, 64'h12345678_00000000, 1'b1,
                32'h100, 32'h12345678, 32'h0, 32'h0,
                4'h0, 4'h0, 32'h12345678};

    @(posedge clock);
    @(posedge clock); #1;
    reset = 0;
    chk_zero("reset");

    foreach (vecs[i]) begin
      clear_log();
      start_load(vecs[i].base, vecs[i].cnt);
      chk($sformatf("v%0d_busy_n1", i), busy, 1);
      chk($sformatf("v%0d_ready_n1", i), in_ready, 1);
      send(vecs[i].bytes, 4 * int'(vecs[i].cnt), vecs[i].gaps, 0);
      wait_done();
      chk($sformatf("v%0d_nwrites", i), wa_q.size(), vecs[i].cnt);
      if (wa_q.size() > 0) begin
        chk($sformatf("v%0d_a0", i), wa_q[0], vecs[i].a0);
        chk($sformatf("v%0d_d0", i), wd_q[0], vecs[i].d0);
        chk($sformatf("v%0d_s0", i), sa_q[0], vecs[i].s0);
      end
      if (vecs[i].cnt == 2 && wa_q.size() > 1) begin
        chk($sformatf("v%0d_a1", i), wa_q[1], vecs[i].a1);
        chk($sformatf("v%0d_d1", i), wd_q[1], vecs[i].d1);
        chk($sformatf("v%0d_s1", i), sa_q[1], vecs[i].s1);
      end
      chk($sformatf("v%0d_checksum", i), checksum, vecs[i].cs);
      chk($sformatf("v%0d_core_rst_n", i), core_reset_n, 1);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_lat", i), lat_err, 0);
      chk($sformatf("v%0d_rdy_wr", i), rdy_err, 0);
    end

    clear_log();
    start_load(32'h77, 16'd0);
    chk("zero_done", done, 1);
    chk("zero_checksum", checksum, 0);
    chk("zero_core_rst_n", core_reset_n, 1);
    chk("zero_busy", busy, 0);
    idle(4);
    chk("zero_nwrites", wa_q.size(), 0);

    clear_log();
    start_load(32'h20, 16'd2);
    send(64'ha1a2a3a4_b1b2b3b4, 8, 1'b0, 1'b1);
    wait_done();
    idle(3);
    chk("ign_nwrites", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      chk("ign_a0", wa_q[0], 32'h20);
      chk("ign_a1", wa_q[1], 32'h21);
      chk("ign_d1", wd_q[1], 32'hb1b2b3b4);
    end
    chk("ign_checksum", checksum, 32'h10101010);

    clear_log();
    start_load(32'h40, 16'd1);
    chk("reload_core_rst_n", core_reset_n, 0);
    chk("reload_done", done, 0);
    chk("reload_checksum", checksum, 0);
    chk("reload_busy", busy, 1);
    send(64'h0f0e0d0c_00000000, 4, 1'b0, 1'b0);
    wait_done();
    chk("reload_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1) chk("reload_a0", wa_q[0], 32'h40);
    chk("reload_cs", checksum, 32'h0f0e0d0c);
    chk("reload_rst_n_after", core_reset_n, 1);

    clear_log();
    start_load(32'h10, 16'd3);
    send(64'h11223344_55660000, 6, 1'b0, 1'b0);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    chk_zero("midrst");
    idle(8);
    chk("midrst_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      chk("midrst_a0", wa_q[0], 32'h10);
      chk("midrst_d0", wd_q[0], 32'h11223344);
    end
    chk("midrst_idle_busy", busy, 0);
    chk("midrst_idle_ready", in_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits between an external byte stream and the instruction-memory write port of the CPU core. It assembles incoming bytes into big-endian instruction words and writes them to consecutive instruction-memory addresses. It holds the core in reset until the load completes, replacing the simulation-only memory preload with a synthesizable write path.

## Interface
- ADDR_W, 32, width of instruction-memory address (matches `ADDRESS_SIZE`)
- DATA_W, 32, instruction word width (matches `DATA_SIZE`); must be a multiple of 8
- CNT_W, 16, width of word_count

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a load; sampled only in IDLE or DONE
- base_addr  in  ADDR_W  first word address; latched on accepted start
- word_count  in  CNT_W  words to load; latched on accepted start
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader accepts a byte this cycle
- im_write_enable  out  1  instruction-memory write strobe
- im_write_address  out  ADDR_W  write word address
- im_write_data  out  DATA_W  write data
- core_reset_n  out  1  active-low reset to CPU core
- busy  out  1  load in progress
- done  out  1  last load completed
- checksum  out  DATA_W  XOR of all words written in the current or last load

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: in_ready=0, core_reset_n=0. start=1 -> latch base_addr/word_count, clear checksum and byte counter. Go to DONE if word_count==0, else LOAD.
- LOAD: in_ready=1, busy=1. Each in_valid&&in_ready shifts in_data into the word register. The first byte of a word lands in bits [DATA_W-1:DATA_W-8] (big-endian). The byte counter runs 0..DATA_W/8-1. Accepting the final byte of a word -> WRITE.
- WRITE (exactly one cycle): im_write_enable=1, im_write_address=current address, im_write_data=assembled word, in_ready=0.
  - checksum ^= word, address += 1 (modulo 2^ADDR_W, wraps silently), remaining -= 1.
  - remaining==0 after decrement -> DONE, else LOAD.
- DONE: done=1, core_reset_n=1, in_ready=0. start=1 -> same actions as IDLE start. core_reset_n returns to 0 from the next cycle.
- start in LOAD or WRITE is ignored. Bytes presented outside LOAD are not consumed. The upstream holds them under valid/ready rules.
- busy = (state==LOAD || state==WRITE).
- im_write_address/data hold their last values when im_write_enable=0.

## Timing
- Reset (any state, mid-load included): next cycle state=IDLE and all outputs are 0: in_ready, im_write_enable, im_write_address, im_write_data, busy, done, checksum. core_reset_n=0. A partial word is discarded and never written.
- Start accepted in cycle N: busy=1, in_ready=1 in N+1.
- Final byte of a word accepted in cycle M: im_write_enable=1 in M+1. in_ready returns to 1 in M+2 unless that word was the last.
- Minimum cycles per word = DATA_W/8 + 1 (5 at DATA_W=32). Stalls on in_valid=0 extend LOAD with no state change.
- Last write in cycle W: done=1, core_reset_n=1, busy=0 in W+1.
- word_count==0 start in cycle N: done=1 in N+1 with no write and checksum=0.
- Upstream rule: in_data is consumed only on in_valid&&in_ready. A byte offered while in_ready=0 must remain stable.

## Test plan
- Reset mid-load:
  - Stimulus: base_addr=0x10, word_count=3, stream 6 bytes, assert reset one cycle.
  - Required: one write only (addr 0x10), then all outputs 0, core_reset_n=0, state IDLE. The 2-byte partial word is never written.
- Basic load:
  - Stimulus: base_addr=0, word_count=2, bytes 20 01 00 05 | 20 02 00 07 with continuous in_valid.
  - Required: writes 0x20010005@0 then 0x20020007@1. Each write is 1 cycle after the 4th byte. done=1, core_reset_n=1, checksum=0x00030002.
- Backpressure and gaps:
  - Stimulus: same data with in_valid toggling every other cycle.
  - Required: identical writes and checksum, no byte lost or duplicated. in_ready=0 during each WRITE cycle.
- Zero count and ignored start:
  - Stimulus: start with word_count=0.
  - Required: done=1 next cycle, no im_write_enable, checksum=0.
  - Stimulus: start pulses during a 2-word load.
  - Required: ignored; exactly 2 writes.
- Address wrap:
  - Stimulus: ADDR_W=4, base_addr=0xF, word_count=2.
  - Required: writes to 0xF then 0x0.
- Reload from DONE:
  - Stimulus: start after a completed load.
  - Required: core_reset_n falls 1 cycle after start, done=0, checksum cleared. The new load completes with its own checksum.
